// File: rtl/depp_pkg.sv
// Shared definitions for the DEPP host: FSM state encoding and the
// command-type codes presented on i_cmd_type.
package depp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETUP   = 2'd1,
        ST_STROBE  = 2'd2,
        ST_RELEASE = 2'd3
    } depp_state_t;

    // Bit 1 selects read, bit 0 selects the data strobe.
    localparam logic [1:0] CMD_AWR = 2'b00;
    localparam logic [1:0] CMD_DWR = 2'b01;
    localparam logic [1:0] CMD_ARD = 2'b10;
    localparam logic [1:0] CMD_DRD = 2'b11;

    function automatic logic cmd_is_read(input logic [1:0] cmd_type);
        return cmd_type[1];
    endfunction

    function automatic logic cmd_is_data(input logic [1:0] cmd_type);
        return cmd_type[0];
    endfunction

endpackage

// File: rtl/depp_sync.sv
// Two-flop synchronizer for a single asynchronous level (the DEPP wait line).
module depp_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [1:0] sync_reg;

    // Shift the async level through two flops; reset clears both.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg <= 2'b00;
        end else begin
            sync_reg <= {sync_reg[0], d};
        end
    end

    assign q = sync_reg[1];

endmodule

// File: rtl/depp_host.sv
// DEPP host master: turns single-byte address/data read/write commands into
// DEPP bus cycles (setup, strobe until wait rises, release until wait falls).
// Optional feature: define DEPP_HOST_TIMEOUT_EN to bound the time spent in
// STROBE and RELEASE by TIMEOUT_CYCLES; otherwise the host waits forever.
module depp_host
    import depp_pkg::*;
#(
    parameter int SETUP_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_cmd_stb,
    input  logic [1:0] i_cmd_type,
    input  logic [7:0] i_cmd_data,
    output logic       o_cmd_busy,
    output logic       o_rsp_stb,
    output logic [7:0] o_rsp_data,
    output logic       o_rsp_timeout,
    output logic       o_astb_n,
    output logic       o_dstb_n,
    output logic       o_write_n,
    output logic [7:0] o_depp,
    output logic       o_depp_oe,
    input  logic [7:0] i_depp,
    input  logic       i_wait
);

    // Last count value of the setup phase (SETUP_CYCLES is at least 1).
    localparam logic [7:0] SETUP_LAST = 8'(SETUP_CYCLES - 1);

    depp_state_t state_reg;
    logic [1:0]  type_reg;
    logic [7:0]  setup_cnt_reg;
    logic        wait_s;

`ifdef DEPP_HOST_TIMEOUT_EN
    // Abort fires on the TIMEOUT_CYCLES-th cycle spent in STROBE or RELEASE.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] wait_cnt_reg;
`endif

    depp_sync u_sync (
        .clk (i_clk),
        .rst (i_rst),
        .d   (i_wait),
        .q   (wait_s)
    );

    assign o_cmd_busy = (state_reg != ST_IDLE);

    // Bus-cycle sequencer; all bus and response outputs are registered here so
    // strobes can never glitch and reset releases them immediately.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg     <= ST_IDLE;
            type_reg      <= CMD_AWR;
            setup_cnt_reg <= 8'd0;
            o_astb_n      <= 1'b1;
            o_dstb_n      <= 1'b1;
            o_write_n     <= 1'b1;
            o_depp        <= 8'd0;
            o_depp_oe     <= 1'b0;
            o_rsp_stb     <= 1'b0;
            o_rsp_data    <= 8'd0;
`ifdef DEPP_HOST_TIMEOUT_EN
            o_rsp_timeout <= 1'b0;
            wait_cnt_reg  <= 8'd0;
`endif
        end else begin
            o_rsp_stb <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    // Commands are only looked at here, so requests while busy drop.
                    if (i_cmd_stb) begin
                        type_reg      <= i_cmd_type;
                        o_write_n     <= cmd_is_read(i_cmd_type);
                        o_depp        <= i_cmd_data;
                        o_depp_oe     <= ~cmd_is_read(i_cmd_type);
                        o_rsp_data    <= 8'd0;
                        setup_cnt_reg <= 8'd0;
                        state_reg     <= ST_SETUP;
                    end
                end

                ST_SETUP: begin
                    // Direction and data have been stable since accept; strobe now.
                    if (setup_cnt_reg == SETUP_LAST) begin
                        if (cmd_is_data(type_reg)) begin
                            o_dstb_n <= 1'b0;
                        end else begin
                            o_astb_n <= 1'b0;
                        end
`ifdef DEPP_HOST_TIMEOUT_EN
                        wait_cnt_reg <= 8'd0;
`endif
                        state_reg <= ST_STROBE;
                    end else begin
                        setup_cnt_reg <= setup_cnt_reg + 8'd1;
                    end
                end

                ST_STROBE: begin
                    // Peripheral acknowledged: sample read data and end the strobe.
                    if (wait_s) begin
                        if (cmd_is_read(type_reg)) begin
                            o_rsp_data <= i_depp;
                        end
                        o_astb_n  <= 1'b1;
                        o_dstb_n  <= 1'b1;
`ifdef DEPP_HOST_TIMEOUT_EN
                        wait_cnt_reg <= 8'd0;
`endif
                        state_reg <= ST_RELEASE;
                    end
`ifdef DEPP_HOST_TIMEOUT_EN
                    else if (wait_cnt_reg == TIMEOUT_LAST) begin
                        o_astb_n      <= 1'b1;
                        o_dstb_n      <= 1'b1;
                        o_depp_oe     <= 1'b0;
                        o_write_n     <= 1'b1;
                        o_rsp_data    <= 8'd0;
                        o_rsp_timeout <= 1'b1;
                        o_rsp_stb     <= 1'b1;
                        state_reg     <= ST_IDLE;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 8'd1;
                    end
`endif
                end

                ST_RELEASE: begin
                    // Handshake closes once the peripheral drops wait.
                    if (!wait_s) begin
                        o_depp_oe <= 1'b0;
                        o_write_n <= 1'b1;
                        o_rsp_stb <= 1'b1;
`ifdef DEPP_HOST_TIMEOUT_EN
                        o_rsp_timeout <= 1'b0;
`endif
                        state_reg <= ST_IDLE;
                    end
`ifdef DEPP_HOST_TIMEOUT_EN
                    else if (wait_cnt_reg == TIMEOUT_LAST) begin
                        o_depp_oe     <= 1'b0;
                        o_write_n     <= 1'b1;
                        o_rsp_data    <= 8'd0;
                        o_rsp_timeout <= 1'b1;
                        o_rsp_stb     <= 1'b1;
                        state_reg     <= ST_IDLE;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 8'd1;
                    end
`endif
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

`ifndef DEPP_HOST_TIMEOUT_EN
    // Without the timeout feature a completion can never be a timeout.
    assign o_rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_depp_host.sv
// Directed bench for depp_host with a cycle-based DEPP responder model.
// Define DEPP_HOST_TIMEOUT_EN for both files to exercise the timeout path.
module tb_depp_host;
    import depp_pkg::*;

    localparam int SETUP = 2;
    localparam int TMO   = 16;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_cmd_stb = 1'b0;
    logic [1:0] i_cmd_type = 2'b00;
    logic [7:0] i_cmd_data = 8'd0;
    logic       o_cmd_busy, o_rsp_stb, o_rsp_timeout;
    logic [7:0] o_rsp_data;
    logic       o_astb_n, o_dstb_n, o_write_n, o_depp_oe;
    logic [7:0] o_depp;
    logic [7:0] i_depp = 8'd0;
    logic       i_wait = 1'b0;

    depp_host #(.SETUP_CYCLES(SETUP), .TIMEOUT_CYCLES(TMO)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_cmd_stb(i_cmd_stb), .i_cmd_type(i_cmd_type), .i_cmd_data(i_cmd_data),
        .o_cmd_busy(o_cmd_busy), .o_rsp_stb(o_rsp_stb), .o_rsp_data(o_rsp_data),
        .o_rsp_timeout(o_rsp_timeout), .o_astb_n(o_astb_n), .o_dstb_n(o_dstb_n),
        .o_write_n(o_write_n), .o_depp(o_depp), .o_depp_oe(o_depp_oe),
        .i_depp(i_depp), .i_wait(i_wait)
    );

    always #5 i_clk = ~i_clk;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) begin
            pass_cnt++;
            $display("chk %-16s got=0x%0h exp=0x%0h ok", tag, got, exp);
        end else begin
            $display("FAIL %-16s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Responder: raise wait resp_delay cycles after a strobe falls (data first),
    // drop it once both strobes are high again.
    logic       resp_en = 1'b1;
    int         resp_delay = 3;
    logic [7:0] resp_byte = 8'd0;
    int         r_cnt = 0;

    always @(negedge i_clk) begin
        if (!resp_en || i_rst) begin
            i_wait = 1'b0;
            r_cnt  = 0;
        end else if (!i_wait) begin
            if (!o_astb_n || !o_dstb_n) begin
                r_cnt = r_cnt + 1;
                if (r_cnt >= resp_delay) begin
                    i_depp = resp_byte;
                    i_wait = 1'b1;
                    r_cnt  = 0;
                end
            end else begin
                r_cnt = 0;
            end
        end else if (o_astb_n && o_dstb_n) begin
            i_wait = 1'b0;
        end
    end

    // Bus monitor: strobe events, bus stability while strobed, responses.
    int         rsp_cnt = 0, astb_falls = 0, dstb_falls = 0;
    int         stable_err = 0, both_err = 0, low_cycles = 0;
    logic       prev_low = 1'b0;
    logic [7:0] lat_depp = 8'd0;
    logic       lat_wn = 1'b1, lat_oe = 1'b0;
    logic [7:0] byte_q[$];

    always @(negedge i_clk) begin
        if (o_rsp_stb) rsp_cnt++;
        if (!o_astb_n && !o_dstb_n) both_err++;
        if (!o_astb_n || !o_dstb_n) begin
            low_cycles++;
            if (!prev_low) begin
                if (!o_astb_n) astb_falls++;
                else dstb_falls++;
                lat_depp = o_depp;
                lat_wn   = o_write_n;
                lat_oe   = o_depp_oe;
                byte_q.push_back(o_depp);
            end else if (o_depp !== lat_depp || o_write_n !== lat_wn) begin
                stable_err++;
            end
            prev_low = 1'b1;
        end else begin
            prev_low = 1'b0;
        end
    end

    task automatic clear_mon();
        @(posedge i_clk);
        rsp_cnt = 0; astb_falls = 0; dstb_falls = 0; low_cycles = 0;
        byte_q.delete();
        @(negedge i_clk);
    endtask

    // Caller sits at a negedge; request is seen by the next posedge.
    task automatic issue(input logic [1:0] t, input logic [7:0] d);
        i_cmd_type = t;
        i_cmd_data = d;
        i_cmd_stb  = 1'b1;
        @(negedge i_clk);
        i_cmd_stb  = 1'b0;
    endtask

    // Returns at the negedge where o_rsp_stb is high; cyc counts negedges waited.
    task automatic wait_rsp(input int limit, output int cyc);
        logic got;
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < limit) begin
            @(negedge i_clk);
            cyc++;
            if (o_rsp_stb) got = 1'b1;
        end
        check("rsp_seen", {31'd0, got}, 32'd1);
    endtask

    task automatic wait_strobe(input int limit);
        logic got;
        int   n;
        got = 1'b0;
        n = 0;
        while (!got && n < limit) begin
            @(negedge i_clk);
            n++;
            if (!o_astb_n || !o_dstb_n) got = 1'b1;
        end
        check("strobe_seen", {31'd0, got}, 32'd1);
    endtask

    int cyc;

    initial begin
        // Reset state, sampled while reset is held.
        repeat (2) @(negedge i_clk);
        check("rst_astb_n", o_astb_n, 1);
        check("rst_dstb_n", o_dstb_n, 1);
        check("rst_write_n", o_write_n, 1);
        check("rst_oe", o_depp_oe, 0);
        check("rst_depp", o_depp, 0);
        check("rst_busy", o_cmd_busy, 0);
        check("rst_rsp_stb", o_rsp_stb, 0);
        check("rst_rsp_data", o_rsp_data, 0);
        check("rst_timeout", o_rsp_timeout, 0);
        i_rst = 1'b0;
        clear_mon();

        // Address write 0x03, wait raised 3 cycles after the strobe falls.
        resp_delay = 3;
        resp_byte  = 8'hEE;
        issue(CMD_AWR, 8'h03);
        check("awr_busy", o_cmd_busy, 1);
        wait_rsp(100, cyc);
        check("awr_latency", cyc, SETUP + 6 + 2);
        check("awr_timeout", o_rsp_timeout, 0);
        check("awr_rsp_data", o_rsp_data, 0);
        repeat (3) @(negedge i_clk);
        check("awr_astb_falls", astb_falls, 1);
        check("awr_dstb_falls", dstb_falls, 0);
        check("awr_write_n", lat_wn, 0);
        check("awr_oe", lat_oe, 1);
        check("awr_depp", lat_depp, 8'h03);
        check("awr_rsp_cnt", rsp_cnt, 1);
        check("awr_idle_wn", o_write_n, 1);
        check("awr_idle_oe", o_depp_oe, 0);
        check("awr_idle_busy", o_cmd_busy, 0);

        // Data read returning 0xA5 with the fastest responder.
        clear_mon();
        resp_delay = 1;
        resp_byte  = 8'hA5;
        issue(CMD_DRD, 8'h00);
        wait_rsp(100, cyc);
        check("drd_latency", cyc, SETUP + 6);
        check("drd_rsp_data", o_rsp_data, 8'hA5);
        repeat (3) @(negedge i_clk);
        check("drd_dstb_falls", dstb_falls, 1);
        check("drd_astb_falls", astb_falls, 0);
        check("drd_write_n", lat_wn, 1);
        check("drd_oe", lat_oe, 0);

        // Four back-to-back data writes, each issued in the response cycle.
        clear_mon();
        resp_delay = 2;
        for (int i = 0; i < 4; i++) begin
            issue(CMD_DWR, 8'h11 + 8'(i));
            wait_rsp(100, cyc);
            check($sformatf("b2b_latency%0d", i), cyc, SETUP + 6 + 1);
            check($sformatf("b2b_rsp_data%0d", i), o_rsp_data, 0);
        end
        repeat (3) @(negedge i_clk);
        check("b2b_dstb_falls", dstb_falls, 4);
        check("b2b_rsp_cnt", rsp_cnt, 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("b2b_byte%0d", i), (i < byte_q.size()) ? byte_q[i] : 8'hxx, 8'h11 + 8'(i));
        end

        // Command pulsed while strobing is dropped.
        clear_mon();
        resp_delay = 6;
        issue(CMD_DWR, 8'h5A);
        wait_strobe(20);
        issue(CMD_AWR, 8'hFF);
        wait_rsp(100, cyc);
        repeat (20) @(negedge i_clk);
        check("ign_rsp_cnt", rsp_cnt, 1);
        check("ign_astb_falls", astb_falls, 0);
        check("ign_dstb_falls", dstb_falls, 1);
        check("ign_byte", (byte_q.size() > 0) ? byte_q[0] : 8'hxx, 8'h5A);
        check("ign_busy", o_cmd_busy, 0);

        // Peripheral never answers.
        clear_mon();
        resp_en = 1'b0;
        issue(CMD_DRD, 8'h00);
`ifdef DEPP_HOST_TIMEOUT_EN
        wait_rsp(100, cyc);
        check("tmo_latency", cyc, SETUP + TMO);
        check("tmo_flag", o_rsp_timeout, 1);
        check("tmo_rsp_data", o_rsp_data, 0);
        check("tmo_astb_n", o_astb_n, 1);
        check("tmo_dstb_n", o_dstb_n, 1);
        check("tmo_oe", o_depp_oe, 0);
        repeat (2) @(negedge i_clk);
        check("tmo_low_cycles", low_cycles, TMO);
`else
        repeat (1000) @(negedge i_clk);
        check("hang_busy", o_cmd_busy, 1);
        check("hang_dstb_n", o_dstb_n, 0);
        check("hang_rsp_cnt", rsp_cnt, 0);
`endif

        // Asynchronous reset in the middle of a strobe.
        @(negedge i_clk);
        i_rst = 1'b1;
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        clear_mon();
        issue(CMD_DWR, 8'h77);
        wait_strobe(20);
        repeat (3) @(negedge i_clk);
        #2;
        i_rst = 1'b1;
        #1;
        check("arst_astb_n", o_astb_n, 1);
        check("arst_dstb_n", o_dstb_n, 1);
        check("arst_oe", o_depp_oe, 0);
        check("arst_busy", o_cmd_busy, 0);
        @(negedge i_clk);
        i_rst = 1'b0;
        repeat (5) @(negedge i_clk);
        check("arst_rsp_cnt", rsp_cnt, 0);

        // Recovery: address read returns 0x3C normally.
        resp_en    = 1'b1;
        resp_delay = 1;
        resp_byte  = 8'h3C;
        issue(CMD_ARD, 8'h00);
        wait_rsp(100, cyc);
        check("rec_rsp_data", o_rsp_data, 8'h3C);
        check("rec_timeout", o_rsp_timeout, 0);
        repeat (3) @(negedge i_clk);
        check("rec_astb_falls", astb_falls, 1);
        check("rec_rsp_cnt", rsp_cnt, 1);
        check("both_strobes", both_err, 0);
        check("bus_stable", stable_err, 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/depp_host.md
DEPP_HOST -- requirements
Module: depp_host

Interface
REQ-001 SHALL have parameter SETUP_CYCLES, default 2: cycles that o_write_n and o_depp are held stable before a strobe falls (minimum 1).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255: maximum cycles spent waiting in STROBE or RELEASE (8-bit counter).
REQ-003 SHALL have port i_clk, input, 1: single clock.
REQ-004 SHALL have port i_rst, input, 1: asynchronous reset, active-high.
REQ-005 SHALL have port i_cmd_stb, input, 1: command request.
REQ-006 SHALL have port i_cmd_type, input, 2: 00 addr-write, 01 data-write, 10 addr-read, 11 data-read.
REQ-007 SHALL have port i_cmd_data, input, 8: write byte.
REQ-008 SHALL have port o_cmd_busy, output, 1: command in progress.
REQ-009 SHALL have port o_rsp_stb, output, 1: one-cycle completion pulse.
REQ-010 SHALL have port o_rsp_data, output, 8: read byte, zero on writes.
REQ-011 SHALL have port o_rsp_timeout, output, 1: completion was a timeout, valid with o_rsp_stb.
REQ-012 SHALL have ports o_astb_n, output, 1 and o_dstb_n, output, 1: DEPP address and data strobes, active-low.
REQ-013 SHALL have ports o_write_n, output, 1: DEPP direction, low means write; o_depp, output, 8: bus out; o_depp_oe, output, 1: bus drive enable.
REQ-014 SHALL have ports i_depp, input, 8: bus in; i_wait, input, 1: DEPP wait from the peripheral bridge.

Function
REQ-015 SHALL pass i_wait through a 2-flop synchronizer (wait_s) before any use.
REQ-016 SHALL implement states IDLE, SETUP, STROBE, RELEASE.
REQ-017 IDLE: when i_cmd_stb is high, SHALL latch type and data, drive o_write_n = type[1], drive o_depp = data, set o_depp_oe = ~type[1], and go to SETUP; o_cmd_busy SHALL be 1 exactly when state != IDLE.
REQ-018 SETUP: after SETUP_CYCLES cycles SHALL go to STROBE, asserting o_astb_n low for type[0]=0 or o_dstb_n low for type[0]=1.
REQ-019 STROBE: on the first cycle with wait_s=1, SHALL capture i_depp into o_rsp_data for reads, raise the strobe, and go to RELEASE.
REQ-020 RELEASE: when wait_s=0, SHALL drop o_depp_oe, set o_write_n=1, go to IDLE and pulse o_rsp_stb with o_rsp_timeout=0.
REQ-021 SHALL never assert both strobes, and SHALL never change o_depp or o_write_n while a strobe is low.
REQ-022 i_cmd_stb while busy SHALL be ignored; there is no queue.
REQ-023 A command presented in the o_rsp_stb cycle (state IDLE) SHALL be accepted.
REQ-024 Minimum command latency, accept to o_rsp_stb, SHALL be SETUP_CYCLES + 2 synchronizer cycles per wait edge + 2.

Reset
REQ-025 i_rst SHALL immediately set state=IDLE, o_astb_n=1, o_dstb_n=1, o_write_n=1, o_depp_oe=0, o_depp=0, o_cmd_busy=0, o_rsp_stb=0, o_rsp_data=0, o_rsp_timeout=0, synchronizer=0, counters=0.
REQ-026 Reset during STROBE SHALL release the strobe asynchronously, and SHALL NOT generate an o_rsp_stb.

Configuration
REQ-027 With DEPP_HOST_TIMEOUT_EN defined, a wait counter SHALL run in STROBE and RELEASE; on reaching TIMEOUT_CYCLES the block SHALL raise strobes, drop o_depp_oe, go to IDLE, and pulse o_rsp_stb with o_rsp_timeout=1 and o_rsp_data=0.
REQ-028 Without DEPP_HOST_TIMEOUT_EN, the block SHALL wait indefinitely, SHALL include no counter, and SHALL tie o_rsp_timeout to 0.

Structure
REQ-029 Package depp_pkg SHALL hold the state enum and the command-type constants (CMD_AWR, CMD_DWR, CMD_ARD, CMD_DRD).
REQ-030 The synchronizer SHALL be sub-module depp_sync, 2 flops wide 1, with async reset; all other logic SHALL be in depp_host.

Verification
REQ-031 Addr-write 0x03 with a bench responder raising wait 3 cycles after astb_n falls -> astb_n low only, write_n=0, o_depp=0x03 stable, one o_rsp_stb, timeout=0.
REQ-032 Data-read with a responder driving 0xA5 before wait rises -> dstb_n low, write_n=1, oe=0, o_rsp_data=0xA5.
REQ-033 Four back-to-back data-writes 0x11..0x14 issued in each o_rsp_stb cycle -> four strobe cycles, bytes in order, no cycle lost.
REQ-034 i_cmd_stb pulsed during STROBE -> ignored, exactly one o_rsp_stb.
REQ-035 With the macro defined, TIMEOUT_CYCLES=16, wait held at 0 -> o_rsp_stb with timeout=1 after 16 STROBE cycles, strobes high; without the macro, still busy after 1000 cycles.
REQ-036 i_rst asserted mid-STROBE -> strobes high and oe=0 in the same cycle, no o_rsp_stb, next command completes normally.
